frac_logic_k_cfg: RTL and testbench
===================================

Name: frac_logic_k_cfg

Overview:
- Parametrised successor to the fixed 4-input fracturable logic element: a LUT-K that fractures into two LUT-(K-1) halves.
- Carries its own configuration-chain segment with a load-tracking FSM, and has optional per-output registers.
- Sits inside the fle/fabric hierarchy of the CLB tile, chained via ccff_head/ccff_tail with neighbouring config segments.
- Fabric clock and programming clock share one pin in this tile generation.

Parameters:
- K, 4, LUT input count; legal range 3..6.
- CFG_W, 2**K+3, configuration bits per instance. Derived; must not be overridden.

Ports:
- prog_clk  in  1  single clock; config shifting and output registers, rising edge.
- pReset  in  1  asynchronous, active-low reset.
- ccff_head  in  1  serial config data in.
- ccff_en  in  1  shift enable for the config chain.
- frac_logic_in  in  K  LUT inputs; index idx = frac_logic_in read as an unsigned number, bit 0 = LSB.
- ff_en  in  1  clock enable for the output registers.
- ccff_tail  out  1  serial config data out = cfg[CFG_W-1].
- cfg_done  out  1  high when the instance is configured and operating.
- frac_logic_out  out  2  logic outputs.

Behaviour:
- Config layout:
  - cfg[2**K-1:0] = LUT truth table.
  - cfg[2**K] = out0 select (1 = full LUT-K, 0 = lower half).
  - cfg[2**K+1] = reg0 enable.
  - cfg[2**K+2] = reg1 enable.
- Shift: on a rising edge with ccff_en=1, cfg[0]<=ccff_head and cfg[i]<=cfg[i-1]. The first bit shifted ends in cfg[CFG_W-1] after CFG_W shifts, so data is sent MSB-first. ccff_en=0 holds cfg.
- Shift counter cnt: width clog2(CFG_W+1). Increments on each shift and saturates at CFG_W. Shifting continues past saturation so data passes through to downstream segments.
- FSM states:
  - EMPTY: after reset.
  - LOAD: ccff_en=1 seen.
  - READY: cnt==CFG_W and ccff_en==0.
- FSM transitions:
  - EMPTY -> LOAD when ccff_en=1; cnt becomes 1.
  - LOAD -> READY on the first edge with ccff_en=0 and cnt==CFG_W.
  - LOAD -> EMPTY on ccff_en=0 with cnt<CFG_W; partial load is discarded and cnt cleared.
  - READY -> LOAD when ccff_en=1; cnt restarts at 1 and the output registers clear to 0.
- cfg_done = (state==READY), registered.
- LUT outputs:
  - lo = cfg[idx mod 2**(K-1)].
  - hi = cfg[2**(K-1) + idx mod 2**(K-1)].
  - lutk = frac_logic_in[K-1] ? hi : lo.
  - c0 = select ? lutk : lo.
  - c1 = hi.
- Outputs:
  - frac_logic_out[n] = regn ? q[n] : cn, gated to 0 whenever cfg_done=0.
  - q[n] updates from cn on edges where cfg_done=1, ccff_en=0 and ff_en=1. Otherwise it holds.
  - If ccff_en and ff_en are high together, ccff_en wins and q takes the reconfig clear.
- Latency: combinational path has 0 cycles from frac_logic_in to output. Registered path has 1 cycle.
- Reset (pReset=0, async): cfg=0, cnt=0, state=EMPTY, q=0, cfg_done=0, ccff_tail=0, frac_logic_out=0. Reset mid-load discards the partial load.

Decomposition:
- Package frac_logic_pkg holds:
  - FSM state enum.
  - cfg_width(K) function.
  - Bit offsets OFS_SEL, OFS_REG0, OFS_REG1.
- Sub-module frac_logic_ccff_chain: shift register, saturating counter and FSM. Outputs cfg and cfg_done.
- Top level holds the LUT decode, output mux and registers.

Test Plan:
- Reset: apply pReset=0 mid-stream -> all outputs 0, cfg_done=0 within the same cycle; after release cfg_done stays 0.
- K=4 AND4 load: shift 19 bits MSB-first: reg1=0, reg0=0, sel=1, LUT=16'h8000; drop ccff_en -> cfg_done=1 next edge. Then:
  - in=4'hF -> out0=1, out1=1.
  - in=4'hE -> out0=0, out1=0.
  - in=4'h7 -> out0=0, out1=1 (hi half, idx low 3 bits = 7).
- Fractured mode: LUT=16'h6996, sel=0 -> out0 = XOR3 of in[2:0]. in=4'b0011 -> out0=0; in=4'b0001 -> out0=1.
- Registered outputs: reg0=1, LUT=16'hFFFF, sel=1, then toggle ff_en:
  - out0 rises 1 cycle after the first ff_en edge.
  - With ff_en=0 it holds.
  - With ccff_en=1 and ff_en=1 together, out0 forced 0 and cfg_done falls next edge.
- Short load: 10 shifts then ccff_en=0 -> state EMPTY, cfg_done stays 0. A full 19-shift reload then succeeds.
- Pass-through: 19+19 shifts -> ccff_tail reproduces the first 19 bits, delayed 19 edges; cnt saturated; cfg_done=1 after ccff_en drops.

Source files
------------

// File: rtl/frac_logic_pkg.sv
// Shared definitions for the fracturable LUT-K logic element.
// Holds the configuration-load state enum, the configuration width
// function and the offsets of the mode bits that sit above the truth table.
package frac_logic_pkg;

   // Configuration-segment load state
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,   // nothing loaded (after reset or aborted load)
      ST_LOAD  = 2'd1,   // bits are being shifted in
      ST_READY = 2'd2    // full segment loaded, element operating
   } cfg_state_e;

   // Mode-bit offsets, relative to the first bit above the 2**K truth table
   localparam int OFS_SEL  = 0;   // out0: 1 = full LUT-K, 0 = lower half
   localparam int OFS_REG0 = 1;   // out0 registered
   localparam int OFS_REG1 = 2;   // out1 registered

   // Configuration bits per instance: truth table plus three mode bits
   function automatic int cfg_width(input int k);
      return (1 << k) + 3;
   endfunction

endpackage

// File: rtl/frac_logic_ccff_chain.sv
// Configuration-chain segment of the fracturable logic element.
// Serial shift register with a saturating shift counter and a load-tracking
// FSM that raises cfg_done once exactly a full segment has been shifted in.
// Ports:
//   prog_clk  - shared fabric/programming clock, rising edge
//   pReset    - asynchronous active-low reset
//   ccff_head - serial configuration data in
//   ccff_en   - shift enable
//   cfg       - parallel configuration contents (cfg[CFG_W-1] is the tail)
//   cfg_done  - registered "segment loaded and operating" flag
module frac_logic_ccff_chain
   import frac_logic_pkg::*;
#(
   parameter int K     = 4,
   parameter int CFG_W = cfg_width(K)
) (
   input  logic             prog_clk,
   input  logic             pReset,
   input  logic             ccff_head,
   input  logic             ccff_en,
   output logic [CFG_W-1:0] cfg,
   output logic             cfg_done
);

   localparam int CNT_W = $clog2(CFG_W + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CFG_W);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [CFG_W-1:0] cfg_d,      cfg_q;
   logic [CNT_W-1:0] cnt_d,      cnt_q;
   cfg_state_e       state_d,    state_q;
   logic             cfg_done_d, cfg_done_q;

   // Next-state logic: shifting, counting and load tracking
   always_comb begin
      cfg_d   = cfg_q;
      cnt_d   = cnt_q;
      state_d = state_q;

      // Shifting is independent of the FSM so data keeps flowing downstream
      // after this segment has saturated.
      if (ccff_en) begin
         cfg_d = {cfg_q[CFG_W-2:0], ccff_head};
      end else begin
         cfg_d = cfg_q;
      end

      case (state_q)
         ST_EMPTY: begin
            if (ccff_en) begin
               state_d = ST_LOAD;
               cnt_d   = CNT_ONE;
            end else begin
               state_d = ST_EMPTY;
            end
         end
         ST_LOAD: begin
            if (ccff_en) begin
               if (cnt_q != CNT_MAX) begin
                  cnt_d = cnt_q + CNT_ONE;
               end else begin
                  cnt_d = cnt_q;
               end
            end else if (cnt_q == CNT_MAX) begin
               state_d = ST_READY;
            end else begin
               // Aborted load: forget the partial segment entirely
               state_d = ST_EMPTY;
               cnt_d   = '0;
               cfg_d   = '0;
            end
         end
         ST_READY: begin
            if (ccff_en) begin
               state_d = ST_LOAD;
               cnt_d   = CNT_ONE;
            end else begin
               state_d = ST_READY;
            end
         end
         default: begin
            state_d = ST_EMPTY;
            cnt_d   = '0;
            cfg_d   = '0;
         end
      endcase

      cfg_done_d = (state_d == ST_READY);
   end

   // State registers
   always_ff @(posedge prog_clk or negedge pReset) begin
      if (!pReset) begin
         cfg_q      <= '0;
         cnt_q      <= '0;
         state_q    <= ST_EMPTY;
         cfg_done_q <= 1'b0;
      end else begin
         cfg_q      <= cfg_d;
         cnt_q      <= cnt_d;
         state_q    <= state_d;
         cfg_done_q <= cfg_done_d;
      end
   end

   assign cfg      = cfg_q;
   assign cfg_done = cfg_done_q;

endmodule

// File: rtl/frac_logic_k_cfg.sv
// Fracturable LUT-K logic element with its own configuration segment.
// The LUT-K splits into two LUT-(K-1) halves; out0 selects full LUT-K or the
// lower half, out1 is always the upper half. Each output can be registered.
// Ports:
//   prog_clk       - shared fabric/programming clock, rising edge
//   pReset         - asynchronous active-low reset
//   ccff_head      - serial configuration data in
//   ccff_en        - configuration shift enable
//   frac_logic_in  - K LUT inputs (unsigned index, bit 0 = LSB)
//   ff_en          - clock enable of the output registers
//   ccff_tail      - serial configuration data out
//   cfg_done       - element configured and operating
//   frac_logic_out - two logic outputs, forced low until configured
module frac_logic_k_cfg
   import frac_logic_pkg::*;
#(
   parameter int K = 4
) (
   input  logic         prog_clk,
   input  logic         pReset,
   input  logic         ccff_head,
   input  logic         ccff_en,
   input  logic [K-1:0] frac_logic_in,
   input  logic         ff_en,
   output logic         ccff_tail,
   output logic         cfg_done,
   output logic [1:0]   frac_logic_out
);

   localparam int CFG_W = cfg_width(K);
   localparam int LUT_N = 1 << K;

   logic [CFG_W-1:0] cfg_s;
   logic             cfg_done_s;
   logic [K-2:0]     lo_idx_s;
   logic             lo_s, hi_s, lutk_s;
   logic [1:0]       c_s;
   logic [1:0]       q_d, q_q;
   logic             sel_s, reg0_s, reg1_s;

   frac_logic_ccff_chain #(
      .K     (K),
      .CFG_W (CFG_W)
   ) u_chain (
      .prog_clk  (prog_clk),
      .pReset    (pReset),
      .ccff_head (ccff_head),
      .ccff_en   (ccff_en),
      .cfg       (cfg_s),
      .cfg_done  (cfg_done_s)
   );

   assign sel_s  = cfg_s[LUT_N + OFS_SEL];
   assign reg0_s = cfg_s[LUT_N + OFS_REG0];
   assign reg1_s = cfg_s[LUT_N + OFS_REG1];

   // LUT decode: both halves share the low K-1 index bits; the top input
   // picks between them to form the full LUT-K.
   always_comb begin
      lo_idx_s = frac_logic_in[K-2:0];
      lo_s     = cfg_s[lo_idx_s];
      hi_s     = cfg_s[{1'b1, lo_idx_s}];
      if (frac_logic_in[K-1]) begin
         lutk_s = hi_s;
      end else begin
         lutk_s = lo_s;
      end
      if (sel_s) begin
         c_s[0] = lutk_s;
      end else begin
         c_s[0] = lo_s;
      end
      c_s[1] = hi_s;
   end

   // Output register next value; a reconfiguration start overrides ff_en
   always_comb begin
      q_d = q_q;
      if (ccff_en) begin
         q_d = 2'b00;
      end else if (cfg_done_s && ff_en) begin
         q_d = c_s;
      end else begin
         q_d = q_q;
      end
   end

   // Output registers
   always_ff @(posedge prog_clk or negedge pReset) begin
      if (!pReset) begin
         q_q <= 2'b00;
      end else begin
         q_q <= q_d;
      end
   end

   // Output select, gated low while the element is not configured
   always_comb begin
      frac_logic_out = 2'b00;
      if (cfg_done_s) begin
         frac_logic_out[0] = reg0_s ? q_q[0] : c_s[0];
         frac_logic_out[1] = reg1_s ? q_q[1] : c_s[1];
      end else begin
         frac_logic_out = 2'b00;
      end
   end

   assign ccff_tail = cfg_s[CFG_W-1];
   assign cfg_done  = cfg_done_s;

endmodule

// File: tb/tb_frac_logic_k_cfg.sv
// Scoreboard bench for frac_logic_k_cfg (K=4): stimulus pushes expected
// outputs from a behavioural model into a queue, a negedge monitor pops and
// compares them against the DUT.
module tb_frac_logic_k_cfg;

   localparam int K    = 4;
   localparam int NLUT = 1 << K;
   localparam int W    = NLUT + 3;
   localparam int HALF = 1 << (K - 1);

   localparam int M_EMPTY = 0;
   localparam int M_LOAD  = 1;
   localparam int M_READY = 2;

   logic         prog_clk = 1'b0;
   logic         pReset;
   logic         ccff_head;
   logic         ccff_en;
   logic [K-1:0] frac_logic_in;
   logic         ff_en;
   logic         ccff_tail;
   logic         cfg_done;
   logic [1:0]   frac_logic_out;

   always #5 prog_clk = ~prog_clk;

   frac_logic_k_cfg #(.K(K)) dut (
      .prog_clk       (prog_clk),
      .pReset         (pReset),
      .ccff_head      (ccff_head),
      .ccff_en        (ccff_en),
      .frac_logic_in  (frac_logic_in),
      .ff_en          (ff_en),
      .ccff_tail      (ccff_tail),
      .cfg_done       (cfg_done),
      .frac_logic_out (frac_logic_out)
   );

   typedef struct {
      logic [1:0] out;
      logic       done;
      logic       tail;
      string      tag;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;

   // Reference model: config contents, shift count, load state, registers
   logic [W-1:0] m_cfg;
   int           m_cnt;
   int           m_st;
   logic [1:0]   m_q;

   task automatic model_reset();
      m_cfg = '0;
      m_cnt = 0;
      m_st  = M_EMPTY;
      m_q   = 2'b00;
   endtask

   function automatic logic [1:0] model_c(input logic [K-1:0] in);
      int idx, low;
      logic [1:0] c;
      idx  = int'(in);
      low  = idx % HALF;
      c[1] = m_cfg[HALF + low];
      c[0] = m_cfg[NLUT] ? m_cfg[idx] : m_cfg[low];
      return c;
   endfunction

   // Apply one rising edge to the model using the inputs currently driven
   task automatic model_edge();
      logic [1:0] c;
      c = model_c(frac_logic_in);
      if (!pReset) begin
         model_reset();
      end else if (ccff_en) begin
         m_cfg = {m_cfg[W-2:0], ccff_head};
         if (m_st == M_LOAD) m_cnt = (m_cnt < W) ? m_cnt + 1 : W;
         else                m_cnt = 1;
         m_st = M_LOAD;
         m_q  = 2'b00;
      end else begin
         if (m_st == M_READY && ff_en) m_q = c;
         if (m_st == M_LOAD) begin
            if (m_cnt == W) begin
               m_st = M_READY;
            end else begin
               m_st  = M_EMPTY;
               m_cnt = 0;
               m_cfg = '0;
            end
         end
      end
   endtask

   task automatic push_expect(input string tag);
      exp_t e;
      logic [1:0] c;
      c      = model_c(frac_logic_in);
      e.done = (m_st == M_READY);
      e.tail = m_cfg[W-1];
      e.out  = 2'b00;
      if (e.done) begin
         e.out[0] = m_cfg[NLUT + 1] ? m_q[0] : c[0];
         e.out[1] = m_cfg[NLUT + 2] ? m_q[1] : c[1];
      end
      e.tag = tag;
      sb.push_back(e);
   endtask

   // One clock: let the edge happen, then drive new inputs and expect
   task automatic cycle(input logic rst_n, input logic en, input logic hd,
                        input logic fe, input logic [K-1:0] in, input string tag);
      @(posedge prog_clk);
      #1;
      model_edge();
      pReset        = rst_n;
      ccff_en       = en;
      ccff_head     = hd;
      ff_en         = fe;
      frac_logic_in = in;
      if (!rst_n) model_reset();
      push_expect(tag);
   endtask

   function automatic logic [K-1:0] rnd_in();
      logic [31:0] r;
      r = $urandom;
      return r[K-1:0];
   endfunction

   function automatic logic rnd_bit();
      logic [31:0] r;
      r = $urandom;
      return r[0];
   endfunction

   function automatic logic [W-1:0] mk_cfg(input logic r1, input logic r0,
                                           input logic sel, input logic [NLUT-1:0] lut);
      return {r1, r0, sel, lut};
   endfunction

   function automatic logic [W-1:0] rnd_cfg();
      logic [W-1:0] v;
      for (int i = 0; i < W; i++) v[i] = rnd_bit();
      return v;
   endfunction

   // Send the first n bits of v, MSB first
   task automatic shift_n(input logic [W-1:0] v, input int n, input string tag);
      for (int i = 0; i < n; i++) cycle(1'b1, 1'b1, v[W-1-i], rnd_bit(), rnd_in(), tag);
   endtask

   task automatic run_idle(input int n, input logic rand_fe, input string tag);
      for (int i = 0; i < n; i++)
         cycle(1'b1, 1'b0, 1'b0, rand_fe ? rnd_bit() : 1'b0, rnd_in(), tag);
   endtask

   // Monitor: compare DUT outputs against the queued expectation
   always @(negedge prog_clk) begin
      exp_t e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         n_cmp++;
         if (frac_logic_out !== e.out) begin
            n_err++;
            $display("FAIL %s.out: got %b want %b (t=%0t)", e.tag, frac_logic_out, e.out, $time);
         end
         n_cmp++;
         if (cfg_done !== e.done) begin
            n_err++;
            $display("FAIL %s.cfg_done: got %b want %b (t=%0t)", e.tag, cfg_done, e.done, $time);
         end
         n_cmp++;
         if (ccff_tail !== e.tail) begin
            n_err++;
            $display("FAIL %s.tail: got %b want %b (t=%0t)", e.tag, ccff_tail, e.tail, $time);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      pReset        = 1'b0;
      ccff_en       = 1'b0;
      ccff_head     = 1'b0;
      ff_en         = 1'b0;
      frac_logic_in = '0;
      model_reset();

      // Reset, then idle unconfigured
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, rnd_in(), "rst");
      run_idle(3, 1'b1, "empty");

      // AND4, full LUT-K on out0
      shift_n(mk_cfg(1'b0, 1'b0, 1'b1, 16'h8000), W, "and4_load");
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'hF, "and4_F");
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'hE, "and4_E");
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'h7, "and4_7");
      run_idle(6, 1'b1, "and4_rnd");

      // Reset in the middle of a load
      shift_n(rnd_cfg(), 7, "midload");
      cycle(1'b0, 1'b1, 1'b1, 1'b1, rnd_in(), "midload_rst");
      cycle(1'b0, 1'b0, 1'b0, 1'b0, rnd_in(), "midload_rst");
      run_idle(3, 1'b1, "post_rst");

      // Fractured XOR3 on out0
      shift_n(mk_cfg(1'b0, 1'b0, 1'b0, 16'h6996), W, "xor_load");
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'b0011, "xor_3");
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'b0001, "xor_1");
      run_idle(6, 1'b1, "xor_rnd");

      // Reset while operating
      cycle(1'b0, 1'b0, 1'b0, 1'b0, rnd_in(), "ready_rst");
      run_idle(3, 1'b1, "post_rst2");

      // Registered out0
      shift_n(mk_cfg(1'b0, 1'b1, 1'b1, 16'hFFFF), W, "reg_load");
      cycle(1'b1, 1'b0, 1'b0, 1'b0, rnd_in(), "reg_hold0");
      cycle(1'b1, 1'b0, 1'b0, 1'b0, rnd_in(), "reg_hold0");
      cycle(1'b1, 1'b0, 1'b0, 1'b1, rnd_in(), "reg_fe");
      cycle(1'b1, 1'b0, 1'b0, 1'b0, rnd_in(), "reg_rise");
      cycle(1'b1, 1'b0, 1'b0, 1'b0, rnd_in(), "reg_hold1");
      cycle(1'b1, 1'b1, 1'b0, 1'b1, rnd_in(), "reg_cfg_wins");
      cycle(1'b1, 1'b0, 1'b0, 1'b1, rnd_in(), "reg_cleared");
      run_idle(2, 1'b1, "reg_after");

      // Short load aborts, full reload succeeds
      shift_n(rnd_cfg(), 10, "short");
      run_idle(3, 1'b1, "short_abort");
      shift_n(rnd_cfg(), W, "reload");
      run_idle(20, 1'b1, "reload_rnd");

      // Pass-through: two segments' worth of bits
      shift_n(rnd_cfg(), W, "pass_a");
      shift_n(rnd_cfg(), W, "pass_b");
      run_idle(8, 1'b1, "pass_rnd");

      // Random configurations
      for (int k = 0; k < 8; k++) begin
         shift_n(rnd_cfg(), W, "rcfg_load");
         run_idle(16, 1'b1, "rcfg_run");
      end

      // Drain the scoreboard
      repeat (3) @(negedge prog_clk);
      #1;
      n_cmp++;
      if (sb.size() != 0) begin
         n_err++;
         $display("FAIL drain: got %0d pending want 0", sb.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
